// File: rtl/fifox_multi_mvb_reader.sv
// Read-side drain engine: pulls a contiguous prefix of FIFOX_MULTI read ports into a registered MVB word.
// Optional item counter on STAT_ITEMS is enabled by defining FIFOX_MULTI_MVB_READER_STATS_EN.

module fifox_multi_mvb_reader_lane #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  keep,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    // Items not read in this word are stored as zero so consumers never see stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= '0;
        else if (load)
            dout <= keep ? din : '0;
    end
endmodule

module fifox_multi_mvb_reader #(
    parameter int DATA_WIDTH    = 64,
    parameter int READ_PORTS    = 4,
    parameter int ACCUM_TIMEOUT = 8,
    parameter int CNT_WIDTH     = 64
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic [READ_PORTS*DATA_WIDTH-1:0] FIFO_DO,
    input  logic [READ_PORTS-1:0]            FIFO_EMPTY,
    output logic [READ_PORTS-1:0]            FIFO_RD,
    input  logic                             RD_EN,
    output logic [READ_PORTS*DATA_WIDTH-1:0] TX_DATA,
    output logic [READ_PORTS-1:0]            TX_VLD,
    output logic                             TX_SRC_RDY,
    input  logic                             TX_DST_RDY,
    output logic [CNT_WIDTH-1:0]             STAT_ITEMS
);
    localparam int ACC_W = (ACCUM_TIMEOUT > 0) ? $clog2(ACCUM_TIMEOUT + 1) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCUM_TIMEOUT);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state, state_nxt;
    logic [ACC_W-1:0]        acc_cnt, acc_cnt_nxt;
    logic [READ_PORTS-1:0]   prefix;
    logic [READ_PORTS-1:0]   rd;
    logic                    run;
    logic                    any, full, slot_free, timed_out, fire;

    // Contiguous non-empty run from port 0; anything past the first empty port is ignored.
    always_comb begin
        prefix = '0;
        run    = 1'b1;
        for (int i = 0; i < READ_PORTS; i++) begin
            prefix[i] = run && !FIFO_EMPTY[i];
            run       = prefix[i];
        end
    end

    assign any       = prefix[0];
    assign full      = &prefix;
    assign slot_free = !TX_SRC_RDY || TX_DST_RDY;
    assign timed_out = (ACCUM_TIMEOUT == 0) || (state == ACCUM && acc_cnt == ACC_MAX);
    assign fire      = RD_EN && slot_free && any && (full || timed_out);
    assign rd        = fire ? prefix : '0;
    assign FIFO_RD   = RESET_N ? rd : '0;

    always_comb begin
        state_nxt   = state;
        acc_cnt_nxt = acc_cnt;
        case (state)
            IDLE: begin
                if (any && !full && !fire && RD_EN) begin
                    state_nxt   = ACCUM;
                    acc_cnt_nxt = ACC_W'(1);
                end
            end
            ACCUM: begin
                if (fire || !any) begin
                    state_nxt   = IDLE;
                    acc_cnt_nxt = '0;
                end else if (RD_EN && acc_cnt != ACC_MAX) begin
                    acc_cnt_nxt = acc_cnt + ACC_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                acc_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            acc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            acc_cnt <= acc_cnt_nxt;
        end
    end

    // A load in the same cycle the consumer accepts keeps SRC_RDY high: back-to-back words.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            TX_SRC_RDY <= 1'b0;
            TX_VLD     <= '0;
        end else if (fire) begin
            TX_SRC_RDY <= 1'b1;
            TX_VLD     <= rd;
        end else if (TX_DST_RDY) begin
            TX_SRC_RDY <= 1'b0;
            TX_VLD     <= '0;
        end
    end

    fifox_multi_mvb_reader_lane #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane [READ_PORTS-1:0] (
        .clk  (CLK),
        .rst_n(RESET_N),
        .load (fire),
        .keep (rd),
        .din  (FIFO_DO),
        .dout (TX_DATA)
    );

`ifdef FIFOX_MULTI_MVB_READER_STATS_EN
    localparam int AV_W = $clog2(READ_PORTS + 1);
    logic [AV_W-1:0] rd_cnt;

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < READ_PORTS; i++)
            rd_cnt = rd_cnt + AV_W'(rd[i]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            STAT_ITEMS <= '0;
        else if (fire)
            STAT_ITEMS <= STAT_ITEMS + CNT_WIDTH'(rd_cnt);
    end
`else
    assign STAT_ITEMS = {CNT_WIDTH{1'b0}};
`endif

endmodule
